msrv32_instr_fetch_buffer: RTL and testbench

MSRV32_INSTR_FETCH_BUFFER -- requirements
Module: msrv32_instr_fetch_buffer

---
 rtl/msrv32_pkg.sv | 27 ++
 rtl/msrv32_instr_fetch_buffer.sv | 111 +++++++++++
 tb/tb_msrv32_instr_fetch_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: default NOP, instruction field positions, fetch entry payload.
package msrv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_W      = 5;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_W      = 5;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/msrv32_instr_fetch_buffer.sv
// Two-entry instruction fetch buffer between instruction memory and decode.
// Head entry is presented combinationally; NOP is shown whenever the buffer is empty.
module msrv32_instr_fetch_buffer
  import msrv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                imem_valid_in,
  input  logic [XLEN-1:0]     imem_data_in,
  input  logic [XLEN-1:0]     imem_pc_in,
  output logic                imem_ready_out,
  input  logic                flush_in,
  input  logic                stall_in,
  output logic                instr_valid_out,
  output logic [XLEN-1:0]     instr_out,
  output logic [XLEN-1:0]     pc_out,
  output logic                misaligned_out,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic [FUNCT3_W-1:0] funct3_out,
  output logic [FUNCT7_W-1:0] funct7_out,
  output logic [RS1_W-1:0]    rs1_addr_out,
  output logic [RS2_W-1:0]    rs2_addr_out,
  output logic [RD_W-1:0]     rd_addr_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;
  fetch_entry_t mem [2];
  fetch_entry_t head;

  assign imem_ready_out  = (state != FULL);
  assign instr_valid_out = (state != EMPTY);
  assign push            = imem_valid_in & imem_ready_out;
  assign pop             = instr_valid_out & ~stall_in;

  // Occupancy tracking; flush overrides every other event
  always_comb begin
    state_next = state;
    if (flush_in) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_next = ONE;
        ONE: begin
          if (push && !pop)      state_next = FULL;
          else if (pop && !push) state_next = EMPTY;
        end
        FULL:  if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_next;
      if (flush_in) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk_in) begin
    if (push && !flush_in) begin
      mem[wr_ptr] <= '{pc: imem_pc_in, instr: imem_data_in,
                       misaligned: (imem_pc_in[1:0] != 2'b00)};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    instr_out      = NOP_INSTR;
    pc_out         = '0;
    misaligned_out = 1'b0;
    if (instr_valid_out) begin
      instr_out      = head.instr;
      pc_out         = head.pc;
      misaligned_out = head.misaligned;
    end
  end

  assign opcode_out   = instr_out[OPCODE_LSB +: OPCODE_W];
  assign funct3_out   = instr_out[FUNCT3_LSB +: FUNCT3_W];
  assign funct7_out   = instr_out[FUNCT7_LSB +: FUNCT7_W];
  assign rs1_addr_out = instr_out[RS1_LSB +: RS1_W];
  assign rs2_addr_out = instr_out[RS2_LSB +: RS2_W];
  assign rd_addr_out  = instr_out[RD_LSB +: RD_W];

endmodule

// File: tb/tb_msrv32_instr_fetch_buffer.sv
// Bench for the fetch buffer: directed scenarios plus random traffic against a queue model.
module tb_msrv32_instr_fetch_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        imem_valid_in;
  logic [31:0] imem_data_in;
  logic [31:0] imem_pc_in;
  logic        imem_ready_out;
  logic        flush_in;
  logic        stall_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        misaligned_out;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic [4:0]  rd_addr_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  msrv32_instr_fetch_buffer dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .imem_valid_in   (imem_valid_in),
    .imem_data_in    (imem_data_in),
    .imem_pc_in      (imem_pc_in),
    .imem_ready_out  (imem_ready_out),
    .flush_in        (flush_in),
    .stall_in        (stall_in),
    .instr_valid_out (instr_valid_out),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .misaligned_out  (misaligned_out),
    .opcode_out      (opcode_out),
    .funct3_out      (funct3_out),
    .funct7_out      (funct7_out),
    .rs1_addr_out    (rs1_addr_out),
    .rs2_addr_out    (rs2_addr_out),
    .rd_addr_out     (rd_addr_out)
  );

  always #5 clk_in = ~clk_in;

  // Model view of the head entry
  function automatic logic exp_valid();
    return q.size() != 0;
  endfunction
  function automatic logic exp_ready();
    return q.size() < 2;
  endfunction
  function automatic logic [31:0] exp_instr();
    return (q.size() != 0) ? q[0].instr : 32'h0000_0013;
  endfunction
  function automatic logic [31:0] exp_pc();
    return (q.size() != 0) ? q[0].pc : 32'h0;
  endfunction
  function automatic logic exp_mis();
    return (q.size() != 0) ? (q[0].pc[1:0] != 2'b00) : 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it
  task automatic cycle(input logic v, input logic [31:0] d, input logic [31:0] p,
                       input logic st, input logic fl);
    bit do_push;
    bit do_pop;
    imem_valid_in = v;
    imem_data_in  = d;
    imem_pc_in    = p;
    stall_in      = st;
    flush_in      = fl;
    do_push = v && (q.size() < 2);
    do_pop  = (q.size() != 0) && !st;
    @(posedge clk_in);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{instr: d, pc: p});
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    imem_valid_in = 1'b1; imem_data_in = 32'hDEAD_BEEF; imem_pc_in = 32'h4;
    stall_in = 1'b0; flush_in = 1'b0;
    q.delete();
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if ({instr_valid_out, imem_ready_out, misaligned_out} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid/ready/mis=%b%b%b want 010",
               instr_valid_out, imem_ready_out, misaligned_out);
    end
    n_tests++;
    if (instr_out !== 32'h0000_0013 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got instr=%h pc=%h want 00000013/00000000", instr_out, pc_out);
    end
    imem_valid_in = 1'b0;
    rst_n_in = 1'b1;
  endtask

  task automatic test_first_fetch();
    cycle(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0);
    imem_valid_in = 1'b0;
    n_tests++;
    if (instr_valid_out !== 1'b1 || instr_out !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL first_fetch: got valid=%b instr=%h want 1/00100093", instr_valid_out, instr_out);
    end
    n_tests++;
    if (rd_addr_out !== 5'd1 || opcode_out !== 7'h13) begin
      n_fail++;
      $display("FAIL first_fields: got rd=%0d opcode=%h want 1/13", rd_addr_out, opcode_out);
    end
    idle();
    n_tests++;
    if (instr_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL first_drain: got valid=%b want 0", instr_valid_out);
    end
  endtask

  task automatic test_stall_full();
    cycle(1'b1, 32'hAAAA_0013, 32'h10, 1'b1, 1'b0);
    cycle(1'b1, 32'hBBBB_0013, 32'h14, 1'b1, 1'b0);
    n_tests++;
    if (imem_ready_out !== 1'b0 || instr_out !== 32'hAAAA_0013) begin
      n_fail++;
      $display("FAIL stall_full: got ready=%b instr=%h want 0/aaaa0013", imem_ready_out, instr_out);
    end
    cycle(1'b1, 32'hCCCC_0013, 32'h18, 1'b1, 1'b0);
    n_tests++;
    if (instr_out !== 32'hAAAA_0013 || pc_out !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_hold: got instr=%h pc=%h want aaaa0013/00000010", instr_out, pc_out);
    end
    idle();
    n_tests++;
    if (instr_out !== 32'hBBBB_0013 || instr_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got instr=%h valid=%b want bbbb0013/1", instr_out, instr_valid_out);
    end
    idle();
    n_tests++;
    if (instr_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: got valid=%b want 0", instr_valid_out);
    end
  endtask

  task automatic test_push_pop_one();
    logic [31:0] w;
    cycle(1'b1, 32'h1000_0013, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      w = 32'h1000_0013 + 32'(i) * 32'h0100_0000;
      cycle(1'b1, w, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      n_tests++;
      if (instr_out !== w || instr_valid_out !== 1'b1 || imem_ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL push_pop_%0d: got instr=%h valid=%b ready=%b want %h/1/1",
                 i, instr_out, instr_valid_out, imem_ready_out, w);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h1111_0013, 32'h20, 1'b1, 1'b0);
    cycle(1'b1, 32'h2222_0013, 32'h24, 1'b1, 1'b0);
    cycle(1'b1, 32'h3333_0013, 32'h28, 1'b0, 1'b1);
    n_tests++;
    if (instr_valid_out !== 1'b0 || instr_out !== 32'h0000_0013 || imem_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: got valid=%b instr=%h ready=%b want 0/00000013/1",
               instr_valid_out, instr_out, imem_ready_out);
    end
    idle();
    n_tests++;
    if (instr_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_lost: got valid=%b instr=%h want 0", instr_valid_out, instr_out);
    end
  endtask

  task automatic test_misaligned();
    cycle(1'b1, 32'h0000_0513, 32'h0000_0102, 1'b1, 1'b0);
    n_tests++;
    if (misaligned_out !== 1'b1 || pc_out !== 32'h0000_0102) begin
      n_fail++;
      $display("FAIL misaligned_set: got mis=%b pc=%h want 1/00000102", misaligned_out, pc_out);
    end
    cycle(1'b1, 32'h0000_0593, 32'h0000_0104, 1'b1, 1'b0);
    idle();
    n_tests++;
    if (misaligned_out !== 1'b0 || pc_out !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL misaligned_clr: got mis=%b pc=%h want 0/00000104", misaligned_out, pc_out);
    end
    idle();
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h4444_0013, 32'h30, 1'b1, 1'b0);
    cycle(1'b1, 32'h5555_0013, 32'h35, 1'b1, 1'b0);
    imem_valid_in = 1'b0;
    #2;
    rst_n_in = 1'b0;
    q.delete();
    #1;
    n_tests++;
    if ({instr_valid_out, imem_ready_out, misaligned_out} !== 3'b010 ||
        instr_out !== 32'h0000_0013 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b ready=%b mis=%b instr=%h pc=%h",
               instr_valid_out, imem_ready_out, misaligned_out, instr_out, pc_out);
    end
    rst_n_in = 1'b1;
    stall_in = 1'b0;
    idle();
    n_tests++;
    if (instr_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_after: got valid=%b want 0", instr_valid_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] ei;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
            1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 5));
      ei = exp_instr();
      n_tests++;
      if ({instr_valid_out, imem_ready_out, misaligned_out} !== {exp_valid(), exp_ready(), exp_mis()} ||
          instr_out !== ei || pc_out !== exp_pc() ||
          opcode_out !== ei[6:0] || funct3_out !== ei[14:12] || funct7_out !== ei[31:25] ||
          rs1_addr_out !== ei[19:15] || rs2_addr_out !== ei[24:20] || rd_addr_out !== ei[11:7]) begin
        n_fail++;
        $display("FAIL random_%0d: got v=%b r=%b m=%b instr=%h pc=%h want v=%b r=%b m=%b instr=%h pc=%h",
                 i, instr_valid_out, imem_ready_out, misaligned_out, instr_out, pc_out,
                 exp_valid(), exp_ready(), exp_mis(), ei, exp_pc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_full();
    test_push_pop_one();
    test_flush();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
